// File: rtl/poly_ram_reader.sv
// poly_ram_reader: streams one 256-coefficient polynomial from the 96-bit coefficient RAM as 12-bit coefficients over valid/ready
//   clk, rst (sync, active-low)
//   start, base_addr   : begin a read of WORDS words starting at base_addr (sampled in IDLE only)
//   ram_raddr          : registered RAM read address; ram_rdata is valid one cycle after it
//   coef_valid/ready   : coefficient handshake; coef_data/coef_idx/coef_last describe the current coefficient
//   busy, done         : busy from the cycle after start until the final transfer; done pulses the cycle after
//   POLY_READER_REDUCE_EN : when defined, coef_data is conditionally reduced modulo 3329
module poly_ram_reader #(
  parameter int WORD_W = 96,
  parameter int COEF_W = 12,
  parameter int ADDR_W = 8,
  parameter int WORDS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [WORD_W-1:0] ram_rdata,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic [COEF_W-1:0] coef_data,
  output logic [7:0]        coef_idx,
  output logic              coef_last,
  output logic              busy,
  output logic              done
);
  localparam int KPW = WORD_W / COEF_W;
  localparam int KW  = $clog2(KPW);
  localparam int WCW = $clog2(WORDS);
  localparam int IW  = $clog2(WORDS + 1);
  localparam logic [IW-1:0]  WORDS_C = IW'(WORDS);
  localparam logic [WCW-1:0] WLAST   = WCW'(WORDS - 1);
  localparam logic [KW-1:0]  KLAST   = KW'(KPW - 1);
  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;
  state_t            state;
  logic [WORD_W-1:0] word_q, pre_q;
  logic              pre_full, req, ret;
  logic [IW-1:0]     issued;
  logic [KW-1:0]     k;
  logic [WCW-1:0]    wcnt;
  logic              fire, k_end, issue;
  logic [COEF_W-1:0] raw;
  // req: an address is on ram_raddr this cycle; ret: its data is on ram_rdata this cycle
  assign fire  = coef_valid && coef_ready;
  assign k_end = fire && k == KLAST;
  assign issue = state == STREAM && !pre_full && !req && !ret && issued < WORDS_C;
  assign raw   = word_q[k*COEF_W +: COEF_W];
  assign coef_idx  = 8'({wcnt, k});
  assign coef_last = coef_valid && k == KLAST && wcnt == WLAST;
`ifdef POLY_READER_REDUCE_EN
  localparam logic [COEF_W-1:0] Q = COEF_W'(3329);
  assign coef_data = raw >= Q ? raw - Q : raw;
`else
  assign coef_data = raw;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      ram_raddr  <= '0;
      word_q     <= '0;
      pre_q      <= '0;
      pre_full   <= 1'b0;
      req        <= 1'b0;
      ret        <= 1'b0;
      issued     <= '0;
      k          <= '0;
      wcnt       <= '0;
      coef_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      req  <= 1'b0;
      ret  <= req;
      case (state)
        IDLE: if (start) begin
          ram_raddr <= base_addr;
          req       <= 1'b1;
          issued    <= IW'(1);
          pre_full  <= 1'b0;
          k         <= '0;
          wcnt      <= '0;
          busy      <= 1'b1;
          state     <= FETCH;
        end
        // the second word is requested right behind the first so that
        // the prefetch register is loaded by the first coefficient cycle
        FETCH: begin
          ram_raddr <= ram_raddr + ADDR_W'(1);
          req       <= 1'b1;
          issued    <= IW'(2);
          state     <= STREAM;
        end
        STREAM: begin
          if (issue) begin
            ram_raddr <= ram_raddr + ADDR_W'(1);
            req       <= 1'b1;
            issued    <= issued + IW'(1);
          end
          if (fire) begin
            k <= k + KW'(1);
            if (k == KLAST) wcnt <= wcnt + WCW'(1);
          end
          // returning data fills an empty word register directly, feeds a word
          // boundary in the same cycle, or otherwise parks in the prefetch register
          if (!coef_valid) begin
            if (ret) begin
              word_q     <= ram_rdata;
              coef_valid <= 1'b1;
            end
          end else if (k_end) begin
            if (pre_full) begin
              word_q   <= pre_q;
              pre_full <= 1'b0;
            end else if (ret) begin
              word_q <= ram_rdata;
            end else begin
              coef_valid <= 1'b0;
            end
          end else if (ret) begin
            pre_q    <= ram_rdata;
            pre_full <= 1'b1;
          end
          if (k_end && wcnt == WLAST) begin
            coef_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_poly_ram_reader.sv
// tb_poly_ram_reader: scoreboard bench for poly_ram_reader with a one-cycle-latency RAM model
module tb_poly_ram_reader;
  logic        clk = 0;
  logic        rst = 0;
  logic        start = 0;
  logic [7:0]  base_addr = 0;
  logic [7:0]  ram_raddr;
  logic [95:0] ram_rdata = '0;
  logic        coef_valid;
  logic        coef_ready = 1;
  logic [11:0] coef_data;
  logic [7:0]  coef_idx;
  logic        coef_last;
  logic        busy;
  logic        done;
  typedef struct packed {logic [11:0] d; logic [7:0] i;} exp_t;
  logic [95:0] mem [256];
  exp_t        sb[$];
  exp_t        e;
  logic [7:0]  aq[$];
  logic [7:0]  last_a = 0;
  int          total = 0, bad = 0, ncyc = 0, s0 = 0;
  bit          rnd_mode = 0, prev_stall = 0;
  logic [11:0] pd;
  logic [7:0]  pi;

  poly_ram_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
    .coef_idx(coef_idx), .coef_last(coef_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ram_rdata <= mem[ram_raddr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] red(input logic [11:0] v);
`ifdef POLY_READER_REDUCE_EN
    return v >= 12'd3329 ? v - 12'd3329 : v;
`else
    return v;
`endif
  endfunction

  always @(negedge clk) begin
    ncyc++;
    if (ram_raddr != last_a) begin
      aq.push_back(ram_raddr);
      last_a = ram_raddr;
    end
    if (!rst) prev_stall = 0;
    else begin
      if (prev_stall) begin
        check("hold_valid", 32'(coef_valid), 1);
        check("hold_data", 32'(coef_data), 32'(pd));
        check("hold_idx", 32'(coef_idx), 32'(pi));
      end
      if (coef_valid && coef_ready) begin
        if (sb.size() == 0) check("unexpected_xfer", 32'(sb.size()), 1);
        else begin
          e = sb.pop_front();
          check("data", 32'(coef_data), 32'(e.d));
          check("idx", 32'(coef_idx), 32'(e.i));
          check("last", 32'(coef_last), 32'(e.i == 8'd255));
        end
      end
      prev_stall = coef_valid && !coef_ready;
      pd = coef_data;
      pi = coef_idx;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    coef_ready = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  task automatic start_poly(input logic [7:0] b, input int pat);
    logic [11:0] v;
    for (int i = 0; i < 256; i++) begin
      v = pat == 0 ? 12'(i) : (pat == 2 && i == 0) ? 12'd3329 : (pat == 2 && i == 1) ? 12'd4095 : 12'($urandom);
      mem[8'(b + 8'(i / 8))][(i % 8) * 12 +: 12] = v;
      sb.push_back({red(v), 8'(i)});
    end
    aq.delete();
    last_a = ram_raddr;
    start = 1;
    base_addr = b;
    s0 = ncyc;
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic to_cycle(input int t);
    while (ncyc - s0 < t) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("done_seen", 32'(done), 1);
    check("sb_empty", 32'(sb.size()), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_raddr"}, 32'(ram_raddr), 0);
    check({tag, "_valid"}, 32'(coef_valid), 0);
    check({tag, "_data"}, 32'(coef_data), 0);
    check({tag, "_idx"}, 32'(coef_idx), 0);
    check({tag, "_last"}, 32'(coef_last), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("rst0");
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    // full-rate stream with timing checks, ignored start mid-stream
    start_poly(8'h20, 0);
    to_cycle(1);
    check("c1_raddr", 32'(ram_raddr), 32'h20);
    check("c1_busy", 32'(busy), 1);
    check("c1_valid", 32'(coef_valid), 0);
    to_cycle(2);
    check("c2_raddr", 32'(ram_raddr), 32'h21);
    to_cycle(3);
    check("c3_valid", 32'(coef_valid), 1);
    check("c3_idx", 32'(coef_idx), 0);
    to_cycle(53);
    check("c53_idx", 32'(coef_idx), 50);
    start = 1;
    base_addr = 8'h80;
    @(posedge clk);
    #1;
    start = 0;
    to_cycle(54);
    check("ign_busy", 32'(busy), 1);
    check("ign_idx", 32'(coef_idx), 51);
    to_cycle(258);
    check("c258_idx", 32'(coef_idx), 255);
    check("c258_last", 32'(coef_last), 1);
    check("c258_done", 32'(done), 0);
    to_cycle(259);
    check("c259_done", 32'(done), 1);
    check("c259_busy", 32'(busy), 0);
    check("c259_valid", 32'(coef_valid), 0);
    check("sb_empty1", 32'(sb.size()), 0);
    // start in the done cycle, same data, random back-pressure
    rnd_mode = 1;
    start_poly(8'h20, 0);
    to_cycle(2);
    check("s2_c2_valid", 32'(coef_valid), 0);
    to_cycle(3);
    check("s2_c3_valid", 32'(coef_valid), 1);
    check("s2_c3_idx", 32'(coef_idx), 0);
    wait_done();
    // address wrap past 0xFF
    @(negedge clk);
    #1;
    start_poly(8'hF0, 1);
    wait_done();
    check("addr_n", 32'(aq.size()), 32);
    for (int i = 0; i < 32 && i < aq.size(); i++) check("addr", 32'(aq[i]), 32'(8'(8'hF0 + i)));
    // reduction boundary values
    rnd_mode = 0;
    @(negedge clk);
    #1;
    start_poly(8'h60, 2);
`ifdef POLY_READER_REDUCE_EN
    to_cycle(3);
    check("red_3329", 32'(coef_data), 0);
    to_cycle(4);
    check("red_4095", 32'(coef_data), 766);
`else
    to_cycle(3);
    check("raw_3329", 32'(coef_data), 3329);
    to_cycle(4);
    check("raw_4095", 32'(coef_data), 4095);
`endif
    wait_done();
    // reset mid-stream, then restart
    @(negedge clk);
    #1;
    start_poly(8'h10, 1);
    to_cycle(103);
    check("pre_rst_idx", 32'(coef_idx), 100);
    rst = 0;
    @(negedge clk);
    #1;
    check_reset_outputs("rst_mid");
    sb.delete();
    rst = 1;
    @(negedge clk);
    #1;
    rnd_mode = 1;
    start_poly(8'h10, 1);
    to_cycle(3);
    check("rst_restart_idx", 32'(coef_idx), 0);
    wait_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
